// File: rtl/mdm_pkg.sv
// Shared definitions for the MDM stream loopback slice: run-time mode encodings
// and a constant-foldable ceil(log2) helper for parameter-derived widths.
package mdm_pkg;

  typedef enum logic [1:0] {
    MDM_MODE_LOOP = 2'd0,
    MDM_MODE_INV  = 2'd1,
    MDM_MODE_PAT  = 2'd2,
    MDM_MODE_RSVD = 2'd3
  } mdm_mode_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mdm_sync_fifo.sv
// Single-clock FIFO with registered storage and extended pointers; the head word
// is shown straight from the read pointer so a push is visible the next cycle.
module mdm_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic [DATA_W-1:0]         push_data_i,
  input  logic                      pop_i,
  output logic [DATA_W-1:0]         head_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset: contents are only observed while non-empty.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/mdm_stream_loopback.sv
// AXI-Stream byte loopback: mode-selected push source into a FIFO whose head is
// forked losslessly to the UART TX stream and the ASK tap, with drop count and LED.
module mdm_stream_loopback
  import mdm_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int DROP_ON_FULL = 1,
  parameter int TAP_EN       = 1,
  parameter int CNT_W        = 16,
  parameter int LED_HOLD     = 5_000_000
) (
  input  logic                         CLOCK,
  input  logic                         RESET_N,
  input  logic [1:0]                   mode,
  input  logic [DATA_W-1:0]            s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  output logic [DATA_W-1:0]            m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [DATA_W-1:0]            a_tdata,
  output logic                         a_tvalid,
  input  logic                         a_tready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [CNT_W-1:0]             drop_cnt,
  output logic                         led
);

  localparam int LED_W = clog2(LED_HOLD + 1);

  logic              rdy_q;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              m_done_q, m_done_d;
  logic              a_done_q, a_done_d;
  logic [LED_W-1:0]  led_q, led_d;

  logic              push, pop, drop, full, empty, is_pat;
  logic              m_hs, a_hs, m_ok, a_ok;
  logic [DATA_W-1:0] push_data, head;
  mdm_mode_e         mode_e;

  assign mode_e = mdm_mode_e'(mode);

  mdm_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i       (CLOCK),
    .rst_ni      (RESET_N),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .level_o     (level)
  );

  // Push source: full is sampled before any same-cycle pop, so a push at full
  // stalls or drops even if the head leaves this cycle.
  always_comb begin
    is_pat    = (mode_e == MDM_MODE_PAT);
    s_tready  = rdy_q;
    push      = 1'b0;
    drop      = 1'b0;
    push_data = s_tdata;
    pat_d     = pat_q;
    if (is_pat) begin
      push      = rdy_q & ~full;
      push_data = pat_q;
      if (push) pat_d = pat_q + DATA_W'(1);
    end else begin
      if (DROP_ON_FULL == 0) s_tready = rdy_q & ~full;
      if (mode_e == MDM_MODE_INV) push_data = ~s_tdata;
      push = s_tvalid & s_tready & ~full;
      drop = s_tvalid & s_tready & full;
    end
  end

  always_comb begin
    m_tvalid = ~empty & ~m_done_q;
    a_tvalid = (TAP_EN != 0) & ~empty & ~a_done_q;
    m_tdata  = empty ? '0 : head;
    a_tdata  = empty ? '0 : head;
    m_hs     = m_tvalid & m_tready;
    a_hs     = a_tvalid & a_tready;
    m_ok     = m_done_q | m_hs;
    a_ok     = (TAP_EN == 0) | a_done_q | a_hs;
    pop      = ~empty & m_ok & a_ok;
    m_done_d = ~pop & m_ok;
    a_done_d = ~pop & (a_done_q | a_hs);
  end

  always_comb begin
    drop_d = drop_q;
    if (drop && !(&drop_q)) drop_d = drop_q + CNT_W'(1);
    led_d = led_q;
    if (push || pop)        led_d = LED_W'(LED_HOLD);
    else if (led_q != '0)   led_d = led_q - LED_W'(1);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rdy_q    <= 1'b0;
      pat_q    <= '0;
      drop_q   <= '0;
      m_done_q <= 1'b0;
      a_done_q <= 1'b0;
      led_q    <= '0;
    end else begin
      rdy_q    <= 1'b1;
      pat_q    <= pat_d;
      drop_q   <= drop_d;
      m_done_q <= m_done_d;
      a_done_q <= a_done_d;
      led_q    <= led_d;
    end
  end

  assign drop_cnt = drop_q;
  assign led      = (led_q != '0);

endmodule

// File: tb/tb_mdm_stream_loopback.sv
// Directed bench for mdm_stream_loopback: a drop-on-full instance and a
// backpressure instance, each checked every cycle against a behavioural model.
module tb_mdm_stream_loopback;

  localparam int DEPTH    = 16;
  localparam int LED_HOLD = 4;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] sTdata = 8'd0;
  logic       sTvalid = 1'b0;
  logic       sTready;
  logic [7:0] mTdata, aTdata;
  logic       mTvalid, aTvalid;
  logic       mTready = 1'b1;
  logic       aTready = 1'b1;
  logic [4:0] level;
  logic [2:0] dropCnt;
  logic       led;

  logic [1:0] mode0 = 2'd0;
  logic [7:0] sTdata0 = 8'd0;
  logic       sTvalid0 = 1'b0;
  logic       sTready0;
  logic [7:0] mTdata0, aTdata0;
  logic       mTvalid0, aTvalid0;
  logic       mTready0 = 1'b1;
  logic       aTready0 = 1'b1;
  logic [4:0] level0;
  logic [2:0] dropCnt0;
  logic       led0;

  int assertCount = 0;
  int failCount   = 0;

  int         lvl, lvl0, ledM;
  logic       mDone, aDone, rdyM;
  logic [7:0] patM;
  logic [2:0] dropM;
  logic [7:0] expM[$], expA[$], exp0[$];

  mdm_stream_loopback #(
    .DATA_W(8), .DEPTH(DEPTH), .DROP_ON_FULL(1), .TAP_EN(1), .CNT_W(3), .LED_HOLD(LED_HOLD)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .mode(mode),
    .s_tdata(sTdata), .s_tvalid(sTvalid), .s_tready(sTready),
    .m_tdata(mTdata), .m_tvalid(mTvalid), .m_tready(mTready),
    .a_tdata(aTdata), .a_tvalid(aTvalid), .a_tready(aTready),
    .level(level), .drop_cnt(dropCnt), .led(led)
  );

  mdm_stream_loopback #(
    .DATA_W(8), .DEPTH(DEPTH), .DROP_ON_FULL(0), .TAP_EN(1), .CNT_W(3), .LED_HOLD(LED_HOLD)
  ) dut0 (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .mode(mode0),
    .s_tdata(sTdata0), .s_tvalid(sTvalid0), .s_tready(sTready0),
    .m_tdata(mTdata0), .m_tvalid(mTvalid0), .m_tready(mTready0),
    .a_tdata(aTdata0), .a_tvalid(aTvalid0), .a_tready(aTready0),
    .level(level0), .drop_cnt(dropCnt0), .led(led0)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    lvl = 0; lvl0 = 0; ledM = 0;
    mDone = 1'b0; aDone = 1'b0; rdyM = 1'b0;
    patM = 8'd0; dropM = 3'd0;
    expM.delete(); expA.delete(); exp0.delete();
  endtask

  // One clock cycle: drive the drop-on-full input, check both DUTs on the falling
  // edge against the model, then advance the model to the next cycle's state.
  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    logic        isPat, acc, pushE, popE, dropE, mValE, aValE, mHs, aHs, acc0, pop0;
    logic [7:0]  pushD;
    logic [31:0] expD;
    sTvalid = valid;
    sTdata  = data;
    @(negedge CLOCK);
    if (!RESET_N) resetModel();
    mValE = (lvl > 0) && !mDone;
    aValE = (lvl > 0) && !aDone;
    checkOutput("level",    32'(level),    32'(lvl));
    checkOutput("m_tvalid", 32'(mTvalid),  32'(mValE));
    checkOutput("a_tvalid", 32'(aTvalid),  32'(aValE));
    checkOutput("s_tready", 32'(sTready),  32'(rdyM));
    checkOutput("drop_cnt", 32'(dropCnt),  32'(dropM));
    checkOutput("led",      32'(led),      32'(ledM != 0));
    checkOutput("level0",   32'(level0),   32'(lvl0));
    checkOutput("s_tready0",32'(sTready0), 32'(rdyM && (lvl0 < DEPTH)));
    checkOutput("m_tvalid0",32'(mTvalid0), 32'(lvl0 > 0));
    checkOutput("drop_cnt0",32'(dropCnt0), 32'd0);
    if (!RESET_N) begin
      checkOutput("reset_m_tdata", 32'(mTdata), 32'd0);
      checkOutput("reset_a_tdata", 32'(aTdata), 32'd0);
      @(posedge CLOCK);
      #1;
      return;
    end
    isPat = (mode == 2'd2);
    acc   = !isPat && sTvalid && rdyM;
    pushE = isPat ? (rdyM && (lvl < DEPTH)) : (acc && (lvl < DEPTH));
    dropE = acc && (lvl == DEPTH);
    pushD = isPat ? patM : ((mode == 2'd1) ? ~sTdata : sTdata);
    mHs   = mValE && mTready;
    aHs   = aValE && aTready;
    popE  = (lvl > 0) && (mDone || mHs) && (aDone || aHs);
    if (mHs) begin
      expD = 'x;
      if (expM.size() > 0) expD = 32'(expM.pop_front());
      checkOutput("m_tdata", 32'(mTdata), expD);
    end
    if (aHs) begin
      expD = 'x;
      if (expA.size() > 0) expD = 32'(expA.pop_front());
      checkOutput("a_tdata", 32'(aTdata), expD);
    end
    if (popE) begin
      mDone = 1'b0; aDone = 1'b0;
    end else begin
      mDone = mDone || mHs; aDone = aDone || aHs;
    end
    lvl = lvl + (pushE ? 1 : 0) - (popE ? 1 : 0);
    if (pushE) begin
      expM.push_back(pushD);
      expA.push_back(pushD);
      if (isPat) patM = patM + 8'd1;
    end
    if (dropE && dropM != 3'd7) dropM = dropM + 3'd1;
    if (pushE || popE) ledM = LED_HOLD;
    else if (ledM > 0) ledM = ledM - 1;

    acc0 = sTvalid0 && rdyM && (lvl0 < DEPTH);
    pop0 = (lvl0 > 0) && mTready0;
    if (pop0) begin
      expD = 'x;
      if (exp0.size() > 0) expD = 32'(exp0.pop_front());
      checkOutput("m_tdata0", 32'(mTdata0), expD);
    end
    if (acc0) exp0.push_back(sTdata0);
    lvl0 = lvl0 + (acc0 ? 1 : 0) - (pop0 ? 1 : 0);
    rdyM = 1'b1;
    @(posedge CLOCK);
    #1;
    if (acc0) sTdata0 = sTdata0 + 8'd1;
  endtask

  initial begin
    resetModel();
    $display("[TB] reset");
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    RESET_N = 1'b1;
    applyStimulus(1'b0, 8'h00);

    $display("[TB] loop 0x00..0xFF");
    mode = 2'd0; mTready = 1'b1; aTready = 1'b1;
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 8'(i));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00);

    $display("[TB] invert");
    mode = 2'd1;
    applyStimulus(1'b1, 8'h5A);
    applyStimulus(1'b1, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00);

    $display("[TB] drop on full");
    mode = 2'd0; mTready = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(8'h40 + i));
    applyStimulus(1'b0, 8'h00);
    mTready = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00);

    $display("[TB] drop counter saturation");
    mTready = 1'b0;
    for (int i = 0; i < 22; i++) applyStimulus(1'b1, 8'(8'h90 + i));
    mTready = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00);

    $display("[TB] fork with tap stalled");
    aTready = 1'b0;
    applyStimulus(1'b1, 8'h30);
    applyStimulus(1'b1, 8'h31);
    applyStimulus(1'b1, 8'h32);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 8'h00);
    aTready = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00);

    $display("[TB] backpressure instance");
    sTdata0 = 8'h10; sTvalid0 = 1'b1; mTready0 = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00);
    mTready0 = 1'b1;
    for (int i = 0; i < 24; i++) applyStimulus(1'b0, 8'h00);
    sTvalid0 = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00);

    $display("[TB] pattern with toggling ready and reset pulse");
    mode = 2'd2;
    for (int i = 0; i < 40; i++) begin
      mTready = i[0];
      applyStimulus(1'b1, 8'hEE);
    end
    RESET_N = 1'b0;
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    RESET_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mTready = i[0];
      applyStimulus(1'b0, 8'h00);
    end
    mode = 2'd0; mTready = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00);

    checkOutput("m_left",  32'(expM.size()), 32'd0);
    checkOutput("a_left",  32'(expA.size()), 32'd0);
    checkOutput("m0_left", 32'(exp0.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
